// File: rtl/mem_pair_processor.sv
// mem_pair_processor: loads 2**AW words into memory A, then combines adjacent
// word pairs into memory B using an operation mode latched at the end of the load.
module mem_pair_processor #(
    parameter int AW = 3,
    parameter int DW = 8,
    localparam int BAW = (AW > 1) ? AW - 1 : 1
) (
    input  logic           clock,
    input  logic           Reset,
    input  logic           Init,
    input  logic           InValid,
    input  logic [DW-1:0]  DataIn,
    output logic           InReady,
    input  logic [1:0]     Mode,
    input  logic [BAW-1:0] RdAddrB,
    output logic [DW-1:0]  RdDataB,
    output logic           Busy,
    output logic           Done
);

    localparam int ADEPTH = 1 << AW;
    localparam int BDEPTH = 1 << (AW - 1);
    localparam logic [AW:0]    COMP_LAST = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0]  PTR_ONE   = AW'(1'b1);
    localparam logic [AW:0]    CNT_ONE   = (AW + 1)'(1'b1);
    localparam logic [BAW-1:0] PAIR_ONE  = BAW'(1'b1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        COMP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_r;
    logic [AW-1:0]  ptr_a_r;
    logic [AW:0]    comp_cnt_r;
    logic [BAW-1:0] pair_cnt_r;
    logic [1:0]     mode_r;
    logic [DW-1:0]  a_word_r;
    logic [DW-1:0]  rd_data_a_r;
    logic           rd_valid_r;
    logic           rd_odd_r;
    logic           a_we_s;
    logic           b_we_s;
    logic           issue_s;

    logic [DW-1:0] mem_a [0:ADEPTH-1];
    logic [DW-1:0] mem_b [0:BDEPTH-1];

    function automatic logic [DW-1:0] combine(input logic [1:0] mode,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (mode)
            2'b00:   r = (a <= b) ? a + b : a - b;
            2'b01:   r = a + b;
            2'b10:   r = a - b;
            2'b11:   r = (a >= b) ? a : b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Init outranks any memory write in the same cycle.
    assign a_we_s  = (state_r == LOAD) && InValid && !Init;
    assign issue_s = (state_r == COMP) && (comp_cnt_r < COMP_LAST) && !Init;
    assign b_we_s  = (state_r == COMP) && rd_valid_r && rd_odd_r && !Init;

    // Control FSM with registered status outputs.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_r    <= IDLE;
            ptr_a_r    <= '0;
            comp_cnt_r <= '0;
            pair_cnt_r <= '0;
            mode_r     <= 2'b00;
            InReady    <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else if (Init) begin
            state_r    <= LOAD;
            ptr_a_r    <= '0;
            comp_cnt_r <= '0;
            pair_cnt_r <= '0;
            InReady    <= 1'b1;
            Busy       <= 1'b1;
            Done       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    InReady <= 1'b0;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                end
                LOAD: begin
                    if (InValid) begin
                        ptr_a_r <= ptr_a_r + PTR_ONE;
                        if (ptr_a_r == {AW{1'b1}}) begin
                            state_r    <= COMP;
                            mode_r     <= Mode;
                            comp_cnt_r <= '0;
                            pair_cnt_r <= '0;
                            InReady    <= 1'b0;
                        end
                    end
                end
                COMP: begin
                    ptr_a_r    <= ptr_a_r + PTR_ONE;
                    comp_cnt_r <= comp_cnt_r + CNT_ONE;
                    if (b_we_s) begin
                        pair_cnt_r <= pair_cnt_r + PAIR_ONE;
                    end
                    if (comp_cnt_r == COMP_LAST) begin
                        state_r    <= DONE;
                        ptr_a_r    <= '0;
                        comp_cnt_r <= '0;
                        Busy       <= 1'b0;
                        Done       <= 1'b1;
                    end
                end
                DONE: begin
                    InReady <= 1'b0;
                    Busy    <= 1'b0;
                    Done    <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    InReady <= 1'b0;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

    // Memory A: load-time write port, registered read port for the compute sweep.
    always_ff @(posedge clock) begin
        if (a_we_s) begin
            mem_a[ptr_a_r] <= DataIn;
        end
        rd_data_a_r <= mem_a[ptr_a_r];
    end

    // Read pipeline tracking: an even word is held until its odd partner arrives.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            rd_valid_r <= 1'b0;
            rd_odd_r   <= 1'b0;
            a_word_r   <= '0;
        end else begin
            rd_valid_r <= issue_s;
            rd_odd_r   <= ptr_a_r[0];
            if (rd_valid_r && !rd_odd_r) begin
                a_word_r <= rd_data_a_r;
            end
        end
    end

    // Memory B write port; results land as soon as the odd word is readable.
    always_ff @(posedge clock) begin
        if (b_we_s) begin
            mem_b[pair_cnt_r] <= combine(mode_r, a_word_r, rd_data_a_r);
        end
    end

    // Memory B read port, read-before-write against the write port above.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            RdDataB <= '0;
        end else begin
            RdDataB <= mem_b[RdAddrB];
        end
    end

endmodule

// File: tb/tb_mem_pair_processor.sv
// Scoreboard bench for mem_pair_processor: randomized loads checked against a
// pair-combine reference model, B reads compared by a decoupled monitor.
module tb_mem_pair_processor;

    localparam int NA = 8;
    localparam int NB = 4;

    logic       clock   = 1'b0;
    logic       Reset   = 1'b1;
    logic       Init    = 1'b0;
    logic       InValid = 1'b0;
    logic [7:0] DataIn  = 8'd0;
    logic       InReady;
    logic [1:0] Mode    = 2'd0;
    logic [1:0] RdAddrB = 2'd0;
    logic [7:0] RdDataB;
    logic       Busy;
    logic       Done;

    int n_checks = 0;
    int n_pass   = 0;
    int model_b [NB];
    int cur_data [NA];
    int exp_q [$];
    logic rd_en   = 1'b0;
    logic rd_pend = 1'b0;

    always #5 clock = ~clock;

    mem_pair_processor #(.AW(3), .DW(8)) dut (
        .clock   (clock),
        .Reset   (Reset),
        .Init    (Init),
        .InValid (InValid),
        .DataIn  (DataIn),
        .InReady (InReady),
        .Mode    (Mode),
        .RdAddrB (RdAddrB),
        .RdDataB (RdDataB),
        .Busy    (Busy),
        .Done    (Done)
    );

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    function automatic int flags();
        return {29'd0, InReady, Busy, Done};
    endfunction

    function automatic int ref_op(input int m, input int a, input int b);
        case (m)
            0:       return (a <= b) ? (a + b) % 256 : (a - b + 256) % 256;
            1:       return (a + b) % 256;
            2:       return (a - b + 256) % 256;
            default: return (a > b) ? a : b;
        endcase
    endfunction

    // Monitor: a read issued in one cycle is due on RdDataB in the next.
    always @(posedge clock) rd_pend <= rd_en;

    always @(negedge clock) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) chk("unexpected_read", 1, 0);
            else chk("rdB", int'(RdDataB), exp_q.pop_front());
        end
    end

    task automatic issue_read(input int addr, input int expv);
        if (expv >= 0) begin
            RdAddrB = addr[1:0];
            rd_en   = 1'b1;
            exp_q.push_back(expv);
        end else begin
            rd_en = 1'b0;
        end
    endtask

    // abort_kind: 0 none, 1 Init in COMP cycle 3, 2 Reset in COMP cycle 6, 3 Reset after 5 words
    task automatic run(input int mode, input int gap_at, input int gap_len, input int abort_kind);
        int nb [NB];
        int n;
        int k;
        bit ok;
        for (int j = 0; j < NB; j++) nb[j] = ref_op(mode, cur_data[2*j], cur_data[2*j+1]);
        @(negedge clock); Init = 1'b1; Mode = mode[1:0];
        @(negedge clock); Init = 1'b0;
        chk("load_entry", flags(), 6);
        ok = 1'b1;
        for (int i = 0; i < NA; i++) begin
            if (i == gap_at) begin
                InValid = 1'b0;
                repeat (gap_len) begin
                    @(negedge clock);
                    if (!(Busy && InReady)) ok = 1'b0;
                end
            end
            if (abort_kind == 3 && i == 5) begin
                Reset = 1'b1;
                #1;
                chk("load_reset_now", flags(), 0);
                @(negedge clock); Reset = 1'b0; InValid = 1'b0;
                repeat (3) @(negedge clock);
                chk("idle_after_reset", flags(), 0);
                return;
            end
            InValid = 1'b1;
            DataIn  = cur_data[i][7:0];
            @(negedge clock);
        end
        InValid = 1'b0;
        chk("load_busy", int'(ok), 1);
        n  = 1;
        ok = 1'b1;
        while (!Done && n < 40) begin
            if (abort_kind == 1 && n == 3) begin
                rd_en = 1'b0;
                Init  = 1'b1;
                @(negedge clock); Init = 1'b0;
                chk("init_in_comp", flags(), 6);
                model_b[0] = -1;
                return;
            end
            if (abort_kind == 2 && n == 6) begin
                rd_en = 1'b0;
                Reset = 1'b1;
                #1;
                chk("comp_reset_now", flags(), 0);
                chk("comp_reset_rd", int'(RdDataB), 0);
                for (int j = 0; j < NB; j++) if (2*j + 3 < 6) model_b[j] = nb[j];
                @(negedge clock); Reset = 1'b0;
                repeat (2) @(negedge clock);
                chk("idle_after_comp_reset", flags(), 0);
                return;
            end
            if (!Busy) ok = 1'b0;
            k = $urandom_range(0, NB - 1);
            if (abort_kind == 2 && n == 5) rd_en = 1'b0;
            else issue_read(k, (2*k + 3 < n) ? nb[k] : model_b[k]);
            Mode = 2'($urandom_range(0, 3));
            @(negedge clock);
            n++;
        end
        rd_en = 1'b0;
        chk("done_latency", n, 10);
        chk("done_flags", flags(), 1);
        chk("comp_busy", int'(ok), 1);
        for (int j = 0; j < NB; j++) model_b[j] = nb[j];
    endtask

    task automatic sweep();
        for (int a = 0; a < NB; a++) begin
            issue_read(a, model_b[a]);
            Mode = 2'($urandom_range(0, 3));
            @(negedge clock);
        end
        rd_en = 1'b0;
        @(negedge clock);
        #1;
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int std_data [NA];
        std_data = '{5, 9, 20, 3, 200, 100, 7, 7};
        for (int j = 0; j < NB; j++) model_b[j] = -1;

        repeat (2) @(negedge clock);
        chk("reset_flags", flags(), 0);
        chk("reset_rd", int'(RdDataB), 0);
        Reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("idle_hold", flags(), 0);

        cur_data = std_data;
        for (int m = 0; m < 4; m++) begin
            run(m, -1, 0, 0);
            sweep();
        end
        run(0, 4, 3, 0);
        sweep();

        run(2, -1, 0, 1);
        for (int i = 0; i < NA; i++) cur_data[i] = i + 1;
        run(1, -1, 0, 0);
        sweep();

        for (int i = 0; i < NA; i++) cur_data[i] = $urandom_range(0, 255);
        run(0, -1, 0, 2);
        sweep();

        run(3, -1, 0, 3);
        sweep();

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NA; i++) cur_data[i] = $urandom_range(0, 255);
            for (int j = 0; j < NB; j++)
                if ($urandom_range(0, 3) == 0) cur_data[2*j+1] = cur_data[2*j];
            run($urandom_range(0, 3), $urandom_range(0, NA), $urandom_range(0, 4), 0);
            sweep();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_pair_processor.md
MEM_PAIR_PROCESSOR -- requirements
Module: mem_pair_processor

Interface
REQ-001 Parameter AW, default 3, meaning: address width of input memory A, giving depth 2**AW words; AW SHALL be >= 1.
REQ-002 Parameter DW, default 8, meaning: data width of every stored word and of every result.
REQ-003 Port clock  input  1  meaning: rising-edge clock for all state.
REQ-004 Port Reset  input  1  meaning: reset, asynchronous, active-high.
REQ-005 Port Init  input  1  meaning: synchronous restart of a load/compute run.
REQ-006 Port InValid  input  1  meaning: DataIn carries a word.
REQ-007 Port DataIn  input  DW  meaning: word to store in memory A.
REQ-008 Port InReady  output  1  meaning: block accepts DataIn this cycle.
REQ-009 Port Mode  input  2  meaning: pair-combine operation select.
REQ-010 Port RdAddrB  input  max(AW-1,1)  meaning: read address into result memory B.
REQ-011 Port RdDataB  output  DW  meaning: registered read data of memory B.
REQ-012 Port Busy  output  1  meaning: high while in LOAD or COMP.
REQ-013 Port Done  output  1  meaning: high while in DONE.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, COMP and DONE.
REQ-015 Memory A SHALL hold 2**AW words; memory B SHALL hold 2**(AW-1) words; both SHALL be synchronous-read with 1-cycle latency.
REQ-016 In IDLE: InReady=0, Busy=0, Done=0; Init SHALL move the FSM to LOAD on the next edge.
REQ-017 In LOAD: InReady=1; each cycle with InValid=1 SHALL write DataIn to A[ptrA] and increment ptrA; a cycle with InValid=0 SHALL leave ptrA and A unchanged.
REQ-018 When the handshake writes address 2**AW-1, the FSM SHALL enter COMP on that edge; ptrA SHALL wrap to 0 and Mode SHALL be latched internally.
REQ-019 COMP SHALL last exactly 2**AW+1 cycles: it reads A[0..2**AW-1] in order, one per cycle, plus one drain cycle; it SHALL then enter DONE.
REQ-020 For each pair k, with a=A[2k] and b=A[2k+1], B[k] SHALL be written exactly once, in the cycle in which b is available from A.
REQ-021 Latched Mode 00: result = a+b if a<=b, else a-b.
REQ-022 Latched Mode 01: result = a+b.
REQ-023 Latched Mode 10: result = a-b.
REQ-024 Latched Mode 11: result = max(a,b).
REQ-025 All arithmetic SHALL be unsigned modulo 2**DW; comparisons SHALL be unsigned.
REQ-026 Mode changes during COMP SHALL have no effect on the current run.
REQ-027 Memory A SHALL NOT be written outside LOAD; memory B SHALL NOT be written outside COMP.
REQ-028 DONE SHALL hold, with Done=1 and InReady=0, until Init or Reset.
REQ-029 Init SHALL have priority over every other condition in all states: on the next edge the FSM enters LOAD with ptrA=0, the pair counter at 0 and Done=0.
REQ-030 Init SHALL NOT clear the contents of memory A or memory B.
REQ-031 RdDataB SHALL equal B[RdAddrB] sampled at the previous edge, in every state.
REQ-032 During COMP, a read of address k in the same cycle that B[k] is written SHALL return the old value (read-before-write).
REQ-033 The latency from the final LOAD handshake to the first cycle with Done=1 SHALL be exactly 2**AW+2 cycles.

Reset
REQ-034 Reset SHALL immediately force state IDLE, ptrA=0, pair counter=0, InReady=0, Busy=0, Done=0 and RdDataB=0.
REQ-035 Reset SHALL NOT be required to clear the memory arrays.
REQ-036 Reset asserted mid-LOAD or mid-COMP SHALL abort the run, with no further writes to A or B after its assertion.

Verification
REQ-037 AW=3, DW=8, Mode=00; load 5,9,20,3,200,100,7,7 -> B = 14,17,100,14 and Done rises 10 cycles after the last handshake.
REQ-038 Same data, Mode=01 -> B = 14,23,44,14 (300 wraps to 44); Mode=10 -> B = 252,17,100,0; Mode=11 -> B = 9,20,200,7.
REQ-039 Load with InValid low for 3 cycles after word 4 -> ptrA holds; results are identical to REQ-037; Busy stays 1 throughout.
REQ-040 Init asserted in cycle 3 of COMP -> the next edge enters LOAD with Done=0; a reload with 1..8 and Mode=01 -> B = 3,7,11,15.
REQ-041 Reset asserted mid-LOAD after 5 words -> immediately IDLE, InReady=0; the FSM stays in IDLE until Init.
REQ-042 In DONE, sweep RdAddrB over 0..3 -> RdDataB returns B[0..3] one cycle later; Mode toggling has no effect.
